// File: rtl/ctrl_multiciclo_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package ctrl_pkg;

    // FSM state codes, also exported on STATE for debug
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        WB_ALU    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        WB_MEM    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        BR_NT     = 4'd10,
        HALT      = 4'd11
    } state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_ADD  = 4'd0,
        CLS_SUB  = 4'd1,
        CLS_RBAD = 4'd2,   // R-type opcode with an unsupported FUNCT7
        CLS_ADDI = 4'd3,
        CLS_LD   = 4'd4,
        CLS_SD   = 4'd5,
        CLS_BEQ  = 4'd6,
        CLS_BNE  = 4'd7,
        CLS_ILL  = 4'd8
    } instr_cls_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Bundle of every control output driven by the FSM
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       load_a;
        logic       load_b;
        logic       load_alu_out;
        logic       load_mdr;
        logic       reg_write;
        logic       dmem_rw;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [2:0] alu_sel;
        logic       mem_to_reg;
        logic       pc_src;
        logic       halted;
    } ctrl_out_t;

    // Overlay the PC <- PC+4 controls onto an output bundle
    function automatic ctrl_out_t with_pc_plus4(input ctrl_out_t o);
        ctrl_out_t r;
        r          = o;
        r.alu_srca = 1'b0;
        r.alu_srcb = SRCB_FOUR;
        r.alu_sel  = ALU_ADD;
        r.pc_src   = 1'b0;
        r.pc_write = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_multiciclo_decode.sv
// Combinational instruction classifier from the IR opcode/function fields.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output instr_cls_e cls_o,
    output logic       illegal_o
);

    // Map the encoding onto one supported instruction class
    always_comb begin
        cls_o = CLS_ILL;
        case (opcode_i)
            OP_R: begin
                if (funct7_i == F7_ADD) begin
                    cls_o = CLS_ADD;
                end else if (funct7_i == F7_SUB) begin
                    cls_o = CLS_SUB;
                end else begin
                    cls_o = CLS_RBAD;
                end
            end
            OP_I: begin
                if (funct3_i == F3_ADDI) cls_o = CLS_ADDI;
                else                     cls_o = CLS_ILL;
            end
            OP_LD: begin
                if (funct3_i == F3_DW) cls_o = CLS_LD;
                else                   cls_o = CLS_ILL;
            end
            OP_SD: begin
                if (funct3_i == F3_DW) cls_o = CLS_SD;
                else                   cls_o = CLS_ILL;
            end
            OP_BR: begin
                if (funct3_i == F3_BEQ) begin
                    cls_o = CLS_BEQ;
                end else if (funct3_i == F3_BNE) begin
                    cls_o = CLS_BNE;
                end else begin
                    cls_o = CLS_ILL;
                end
            end
            default: cls_o = CLS_ILL;
        endcase
    end

    // Any encoding that cannot complete, including a bad R-type FUNCT7
    assign illegal_o = (cls_o == CLS_ILL) || (cls_o == CLS_RBAD);

endmodule

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM sequencing the 64-bit RISC-V datapath.
module ctrl_multiciclo
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic [6:0] FUNCT7,
    input  logic       IGUAL,
    output logic       PC_WRITE,
    output logic       IR_WRITE,
    output logic       LOAD_A,
    output logic       LOAD_B,
    output logic       LOAD_ALU_OUT,
    output logic       LOAD_MDR,
    output logic       REG_WRITE,
    output logic       DMEM_RW,
    output logic       MEM32_WR,
    output logic       ALU_SRCA,
    output logic [1:0] ALU_SRCB,
    output logic [2:0] ALU_SEL,
    output logic       MEM_TO_REG,
    output logic       PC_SRC,
    output logic [3:0] STATE,
    output logic       HALTED
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       run_q, run_d;     // low from reset until the first edge after release
    instr_cls_e cls_s;
    logic       illegal_s;
    logic       cnt_last_s;
    logic       br_taken_s;
    ctrl_out_t  out_s;

    ctrl_decode u_decode (
        .opcode_i  (OPCODE),
        .funct3_i  (FUNCT3),
        .funct7_i  (FUNCT7),
        .cls_o     (cls_s),
        .illegal_o (illegal_s)
    );

    assign cnt_last_s = (cnt_q == CNT_LAST);
    assign br_taken_s = ((cls_s == CLS_BEQ) && IGUAL) || ((cls_s == CLS_BNE) && !IGUAL);

    // State register, memory wait counter and post-reset run flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= FETCH;
            cnt_q   <= 4'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        run_d   = 1'b1;
        if (!run_q) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (cnt_last_s) state_d = DECODE;
                    else            cnt_d   = cnt_q + 4'd1;
                end
                DECODE: begin
                    case (cls_s)
                        CLS_ADD, CLS_SUB, CLS_RBAD: state_d = EXEC_R;
                        CLS_ADDI:                   state_d = EXEC_I;
                        CLS_LD, CLS_SD:             state_d = MEM_ADDR;
                        CLS_BEQ, CLS_BNE:           state_d = BRANCH;
                        default:                    state_d = HALT;
                    endcase
                end
                EXEC_R: begin
                    if (illegal_s) state_d = HALT;
                    else           state_d = WB_ALU;
                end
                EXEC_I:   state_d = WB_ALU;
                WB_ALU:   state_d = FETCH;
                MEM_ADDR: begin
                    if (cls_s == CLS_LD)      state_d = MEM_READ;
                    else if (cls_s == CLS_SD) state_d = MEM_WRITE;
                    else                      state_d = HALT;
                end
                MEM_READ: begin
                    if (cnt_last_s) state_d = WB_MEM;
                    else            cnt_d   = cnt_q + 4'd1;
                end
                WB_MEM:    state_d = FETCH;
                MEM_WRITE: state_d = FETCH;
                BRANCH: begin
                    if (br_taken_s) state_d = FETCH;
                    else            state_d = BR_NT;
                end
                BR_NT:   state_d = FETCH;
                HALT:    state_d = HALT;
                default: state_d = HALT;
            endcase
        end
    end

    // Control outputs per state; branch PC load is Mealy on IGUAL
    always_comb begin
        out_s = '0;
        if (run_q) begin
            case (state_q)
                FETCH: out_s.ir_write = cnt_last_s;
                DECODE: begin
                    out_s.load_a       = 1'b1;
                    out_s.load_b       = 1'b1;
                    out_s.alu_srca     = 1'b0;
                    out_s.alu_srcb     = SRCB_IMM_SH;
                    out_s.alu_sel      = ALU_ADD;
                    out_s.load_alu_out = 1'b1;
                end
                EXEC_R: begin
                    if (!illegal_s) begin
                        out_s.alu_srca     = 1'b1;
                        out_s.alu_srcb     = SRCB_B;
                        out_s.alu_sel      = (cls_s == CLS_SUB) ? ALU_SUB : ALU_ADD;
                        out_s.load_alu_out = 1'b1;
                    end else begin
                        out_s = '0;
                    end
                end
                EXEC_I, MEM_ADDR: begin
                    out_s.alu_srca     = 1'b1;
                    out_s.alu_srcb     = SRCB_IMM;
                    out_s.alu_sel      = ALU_ADD;
                    out_s.load_alu_out = 1'b1;
                end
                WB_ALU: begin
                    out_s            = with_pc_plus4(out_s);
                    out_s.reg_write  = 1'b1;
                    out_s.mem_to_reg = 1'b0;
                end
                MEM_READ: out_s.load_mdr = cnt_last_s;
                WB_MEM: begin
                    out_s            = with_pc_plus4(out_s);
                    out_s.reg_write  = 1'b1;
                    out_s.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    out_s         = with_pc_plus4(out_s);
                    out_s.dmem_rw = 1'b1;
                end
                BRANCH: begin
                    out_s.alu_srca = 1'b1;
                    out_s.alu_srcb = SRCB_B;
                    out_s.alu_sel  = ALU_CMP;
                    out_s.pc_write = br_taken_s;
                    out_s.pc_src   = br_taken_s;
                end
                BR_NT:   out_s        = with_pc_plus4(out_s);
                HALT:    out_s.halted = 1'b1;
                default: out_s        = '0;
            endcase
        end else begin
            out_s = '0;
        end
    end

    assign PC_WRITE     = out_s.pc_write;
    assign IR_WRITE     = out_s.ir_write;
    assign LOAD_A       = out_s.load_a;
    assign LOAD_B       = out_s.load_b;
    assign LOAD_ALU_OUT = out_s.load_alu_out;
    assign LOAD_MDR     = out_s.load_mdr;
    assign REG_WRITE    = out_s.reg_write;
    assign DMEM_RW      = out_s.dmem_rw;
    assign MEM32_WR     = 1'b0;
    assign ALU_SRCA     = out_s.alu_srca;
    assign ALU_SRCB     = out_s.alu_srcb;
    assign ALU_SEL      = out_s.alu_sel;
    assign MEM_TO_REG   = out_s.mem_to_reg;
    assign PC_SRC       = out_s.pc_src;
    assign STATE        = state_q;
    assign HALTED       = out_s.halted;

endmodule
